lif_neuron_array: RTL and testbench



---
 rtl/lif_neuron_array.sv | 110 +++++++++++
 tb/tb_lif_neuron_array.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//
// Array of N_NEURONS leaky integrate-and-fire neurons. They share a clock, a time-step strobe
// and a firing threshold. On every step cycle each non-refractory neuron works out
//   sum = (v >> LEAK_SHIFT) + current
// in WIDTH+1 bits and clips it to 2^WIDTH-1. If sum reaches threshold, the neuron spikes for
// one cycle and then ignores the next REFRACT step cycles. Refractory neurons ignore their
// input and hold their membrane potential.
//
// Build option:
//   LIF_SOFT_RESET_EN  defined   : post-spike membrane = sum - threshold (residual kept)
//                      undefined : post-spike membrane = 0 (hard reset, default)
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset, clears membranes, counters and spikes
//   step       time-step strobe, one update of every neuron per cycle where high
//   threshold  unsigned firing threshold, sampled on every step cycle
//   current    per-neuron unsigned input, neuron i at [i*WIDTH +: WIDTH]
//   spike      registered one-cycle spike pulses, bit i = neuron i
//   state      registered membrane potentials, same packing as current

module lif_neuron_array #(
   parameter int unsigned N_NEURONS  = 4,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LEAK_SHIFT = 1,
   parameter int unsigned REFRACT    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       step,
   input  logic [WIDTH-1:0]           threshold,
   input  logic [N_NEURONS*WIDTH-1:0] current,
   output logic [N_NEURONS-1:0]       spike,
   output logic [N_NEURONS*WIDTH-1:0] state
);

   // Refractory counter width. It is at least one bit so that REFRACT = 0 still builds.
   localparam int unsigned RW_RAW = $clog2(REFRACT + 1);
   localparam int unsigned RW     = (RW_RAW < 1) ? 1 : RW_RAW;

   localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT);
   localparam logic [RW-1:0] R_ONE        = RW'(1);

   for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron

      logic [WIDTH-1:0] v_q, v_d;
      logic [RW-1:0]    r_q, r_d;
      logic             spk_q, spk_d;

      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] leaked;
      logic [WIDTH:0]   raw_sum;
      logic [WIDTH-1:0] sum;
      logic             fire;
      logic [WIDTH-1:0] post_spike;

      assign cur = current[i*WIDTH +: WIDTH];

      // Leak, integrate and clip. The extra top bit of raw_sum flags overflow.
      always_comb begin
         leaked  = v_q >> LEAK_SHIFT;
         raw_sum = {1'b0, leaked} + {1'b0, cur};
         sum     = raw_sum[WIDTH] ? {WIDTH{1'b1}} : raw_sum[WIDTH-1:0];
         fire    = (sum >= threshold);
`ifdef LIF_SOFT_RESET_EN
         // sum >= threshold whenever this is used, so the result cannot underflow.
         post_spike = sum - threshold;
`else
         post_spike = '0;
`endif
      end

      // Next-state logic. Without a step, membrane and counter hold and no spike is emitted.
      always_comb begin
         v_d   = v_q;
         r_d   = r_q;
         spk_d = 1'b0;
         if (step) begin
            if (r_q != '0) begin
               // Refractory: input ignored, only the step counter advances.
               r_d = r_q - R_ONE;
            end else if (fire) begin
               spk_d = 1'b1;
               v_d   = post_spike;
               r_d   = REFRACT_LOAD;
            end else begin
               v_d = sum;
            end
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v_q   <= '0;
            r_q   <= '0;
            spk_q <= 1'b0;
         end else begin
            v_q   <= v_d;
            r_q   <= r_d;
            spk_q <= spk_d;
         end
      end

      assign state[i*WIDTH +: WIDTH] = v_q;
      assign spike[i]                = spk_q;

   end : g_neuron

endmodule

// File: tb/tb_lif_neuron_array.sv
// Testbench for lif_neuron_array with default parameters (4 neurons, 8 bits, leak shift 1,
// refractory 2). It runs the directed scenarios first, then randomized steps, thresholds and
// currents, and compares every neuron against a behavioural model after every cycle.

module tb_lif_neuron_array;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int LS = 1;
   localparam int RF = 2;
   localparam int VMAX = (1 << W) - 1;

   logic           clk;
   logic           rst;
   logic           step;
   logic [W-1:0]   threshold;
   logic [N*W-1:0] current;
   logic [N-1:0]   spike;
   logic [N*W-1:0] state;

   int n_vec;
   int n_err;

   // Behavioural model state.
   int mv  [N];
   int mr  [N];
   int msp [N];

   lif_neuron_array #(
      .N_NEURONS  (N),
      .WIDTH      (W),
      .LEAK_SHIFT (LS),
      .REFRACT    (RF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .threshold (threshold),
      .current   (current),
      .spike     (spike),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      n_vec++;
      if (got !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mr[i] = 0;
         msp[i] = 0;
      end
   endfunction

   function automatic void model_step(input logic st, input int thr, input logic [N*W-1:0] cur);
      int s;
      for (int i = 0; i < N; i++) begin
         msp[i] = 0;
         if (st) begin
            if (mr[i] > 0) begin
               mr[i] = mr[i] - 1;
            end else begin
               s = (mv[i] / (1 << LS)) + int'(cur[i*W +: W]);
               if (s > VMAX) s = VMAX;
               if (s >= thr) begin
                  msp[i] = 1;
`ifdef LIF_SOFT_RESET_EN
                  mv[i] = s - thr;
`else
                  mv[i] = 0;
`endif
                  mr[i] = RF;
               end else begin
                  mv[i] = s;
               end
            end
         end
      end
   endfunction

   task automatic compare_all(input string ctx);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s state[%0d]", ctx, i), 32'(state[i*W +: W]), mv[i]);
         check($sformatf("%s spike[%0d]", ctx, i), 32'(spike[i]), msp[i]);
      end
   endtask

   // Called at a falling edge: drive inputs, advance the model, then sample after the next rising edge.
   task automatic tick(input string ctx, input logic st, input logic [W-1:0] thr,
                       input logic [N*W-1:0] cur);
      step      = st;
      threshold = thr;
      current   = cur;
      model_step(st, int'(thr), cur);
      @(posedge clk);
      @(negedge clk);
      compare_all(ctx);
   endtask

   // Asynchronous reset pulse between clock edges. Outputs must clear with no clock edge.
   task automatic do_reset(input string ctx);
      rst = 1'b0;
      #1;
      check({ctx, " rst state"}, state, 0);
      check({ctx, " rst spike"}, 32'(spike), 0);
      model_clear();
      #1;
      rst = 1'b1;
   endtask

   initial begin : main
      int exp_seq [12];
      logic [N*W-1:0] cur;
      logic [W-1:0]   thr;
      logic           st;

      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      step = 1'b0;
      threshold = '0;
      current = '0;
      model_clear();

      #2;
      check("por state", state, 0);
      check("por spike", 32'(spike), 0);
      @(negedge clk);
      rst = 1'b1;

      // Neuron 0 integrates 64 per step at threshold 127.
      exp_seq = '{64, 96, 112, 120, 124, 126, 0, 0, 0, 64, 96, 112};
      for (int k = 0; k < 12; k++) begin
         tick("s1", 1'b1, 8'd127, 32'h0000_0040);
         check($sformatf("s1 ch0 step%0d", k + 1), 32'(state[7:0]), exp_seq[k]);
         check($sformatf("s1 ch0 spike step%0d", k + 1), 32'(spike[0]), (k == 6) ? 1 : 0);
      end

      // Neuron 1 at 200 spikes on the first step.
      @(negedge clk);
      do_reset("s2");
      tick("s2", 1'b1, 8'd127, 32'h0000_C800);
`ifdef LIF_SOFT_RESET_EN
      check("s2 ch1 residual", 32'(state[15:8]), 73);
`else
      check("s2 ch1 hard", 32'(state[15:8]), 0);
`endif
      check("s2 ch1 spike", 32'(spike[1]), 1);

      // Saturation: threshold 255, neuron 2 at 200.
      @(negedge clk);
      do_reset("s3");
      tick("s3a", 1'b1, 8'd255, 32'h00C8_0000);
      check("s3 step1 v", 32'(state[23:16]), 200);
      check("s3 step1 spike", 32'(spike[2]), 0);
      tick("s3b", 1'b1, 8'd255, 32'h00C8_0000);
      check("s3 step2 spike", 32'(spike[2]), 1);

      // Step gating: strobe every third cycle.
      @(negedge clk);
      do_reset("s4");
      for (int k = 0; k < 30; k++)
         tick("s4", (k % 3) == 0, 8'd127, 32'h0000_0040);

      // Reset in the middle of the refractory period.
      @(negedge clk);
      do_reset("s5");
      for (int k = 0; k < 7; k++) tick("s5", 1'b1, 8'd127, 32'h0000_0040);
      check("s5 spiked", 32'(spike[0]), 1);
      tick("s5", 1'b1, 8'd127, 32'h0000_0040);
      do_reset("s5 mid");
      tick("s5 post", 1'b1, 8'd127, 32'h0000_0040);
      check("s5 post v", 32'(state[7:0]), 64);

      // Independence: 64, 0, 255, 127 at the same time.
      @(negedge clk);
      do_reset("s6");
      for (int k = 0; k < 12; k++)
         tick("s6", 1'b1, 8'd127, {8'd127, 8'd255, 8'd0, 8'd64});

      // Randomized traffic, including threshold 0 and a few mid-run resets.
      @(negedge clk);
      do_reset("rnd");
      thr = 8'($urandom);
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 15) == 0) thr = 8'($urandom);
         if ($urandom_range(0, 40) == 0) thr = '0;
         st = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++)
            cur[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 60));
         tick("rnd", st, thr, cur);
         if ($urandom_range(0, 99) == 0) do_reset("rnd mid");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
